// File: rtl/spi_regif_pkg.sv
// Shared definitions for the SPI slave register interface: FSM states and
// command-word field layout.
package spi_regif_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_REQ,
        RD_CAP,
        RD_PUSH,
        RD_DRAIN
    } state_t;

    localparam int RW_BIT    = 31;
    localparam int LEN_MSB   = 30;
    localparam int LEN_LSB   = 24;
    localparam int RSV_MSB   = 23;
    localparam int MAX_BURST = 128;
    // Wide enough to hold MAX_BURST itself, not just MAX_BURST-1
    localparam int CNT_W     = $clog2(MAX_BURST) + 1;

    function automatic logic [CNT_W-1:0] burst_len(input logic [31:0] cmd);
        return CNT_W'(cmd[LEN_MSB:LEN_LSB]) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_slave_regif.sv
// Turns a stream of received SPI words into register write/read bursts and
// feeds read data back to the SPI transmit FIFO.
module spi_slave_regif
    import spi_regif_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DW     = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DW-1:0]     rx_data,
    input  logic              rx_data_valid,
    input  logic              frame_abort,
    output logic [DW-1:0]     tx_data,
    output logic              tx_data_valid,
    input  logic              tx_data_ready,
    input  logic              tx_error,
    output logic              reg_wr,
    output logic              reg_rd,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DW-1:0]     reg_wdata,
    input  logic [DW-1:0]     reg_rdata,
    output logic              cmd_error,
    output logic              busy,
    output logic [7:0]        underrun_cnt
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n, reg_addr_n;
    logic [CNT_W-1:0]  remain, remain_n, len, len_n, cnt, cnt_n;
    logic [DW-1:0]     wdata_n, txd_n;
    logic              wr_n, rd_n, err_n, txv_n, rd_state, rsv;

    assign busy     = (state != IDLE);
    assign rd_state = (state != IDLE) && (state != WRITE);
    assign rsv      = |(rx_data[RSV_MSB:0] >> ADDR_W);

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        remain_n   = remain;
        len_n      = len;
        cnt_n      = (rd_state && rx_data_valid && cnt != '1) ? cnt + CNT_W'(1) : cnt;
        wr_n       = 1'b0;
        rd_n       = 1'b0;
        err_n      = 1'b0;
        reg_addr_n = reg_addr;
        wdata_n    = reg_wdata;
        txv_n      = tx_data_valid;
        txd_n      = tx_data;

        case (state)
            IDLE: begin
                if (rx_data_valid) begin
                    if (rsv) begin
                        err_n = 1'b1;
                    end else begin
                        addr_n   = rx_data[ADDR_W-1:0];
                        len_n    = burst_len(rx_data);
                        remain_n = burst_len(rx_data);
                        cnt_n    = '0;
                        if (rx_data[RW_BIT]) begin
                            state_n    = RD_REQ;
                            rd_n       = 1'b1;
                            reg_addr_n = rx_data[ADDR_W-1:0];
                        end else begin
                            state_n = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                if (rx_data_valid) begin
                    wr_n       = 1'b1;
                    reg_addr_n = addr;
                    wdata_n    = rx_data;
                    addr_n     = addr + ADDR_W'(1);
                    remain_n   = remain - CNT_W'(1);
                    if (remain == CNT_W'(1)) state_n = IDLE;
                end
            end
            RD_REQ: state_n = RD_CAP;
            RD_CAP: begin
                txd_n   = reg_rdata;
                txv_n   = 1'b1;
                state_n = RD_PUSH;
            end
            RD_PUSH: begin
                if (tx_data_valid && tx_data_ready) begin
                    txv_n = 1'b0;
                    if (remain > CNT_W'(1)) begin
                        addr_n     = addr + ADDR_W'(1);
                        remain_n   = remain - CNT_W'(1);
                        rd_n       = 1'b1;
                        reg_addr_n = addr + ADDR_W'(1);
                        state_n    = RD_REQ;
                    end else begin
                        state_n = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: if (cnt_n >= len) state_n = IDLE;
            default:  state_n = IDLE;
        endcase

        // Abort beats everything, including an rx word arriving in the same cycle
        if (frame_abort) begin
            state_n = IDLE;
            wr_n    = 1'b0;
            rd_n    = 1'b0;
            err_n   = 1'b0;
            txv_n   = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= IDLE;
            addr          <= '0;
            remain        <= '0;
            len           <= '0;
            cnt           <= '0;
            reg_wr        <= 1'b0;
            reg_rd        <= 1'b0;
            reg_addr      <= '0;
            reg_wdata     <= '0;
            cmd_error     <= 1'b0;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            underrun_cnt  <= '0;
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            remain        <= remain_n;
            len           <= len_n;
            cnt           <= cnt_n;
            reg_wr        <= wr_n;
            reg_rd        <= rd_n;
            reg_addr      <= reg_addr_n;
            reg_wdata     <= wdata_n;
            cmd_error     <= err_n;
            tx_data       <= txd_n;
            tx_data_valid <= txv_n;
            if (tx_error && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Scoreboard bench: stimulus pushes expected register writes / tx words into
// queues, a negedge monitor pops and compares whenever the DUT strobes.
module tb_spi_slave_regif;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] rx_data;
    logic        rx_data_valid;
    logic        frame_abort;
    logic [31:0] tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic        tx_error;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        cmd_error;
    logic        busy;
    logic [7:0]  underrun_cnt;

    spi_slave_regif #(.ADDR_W(8), .DW(32)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .frame_abort(frame_abort),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .tx_error(tx_error), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .cmd_error(cmd_error),
        .busy(busy), .underrun_cnt(underrun_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    logic [39:0] wr_q[$];
    logic [31:0] tx_q[$];
    logic [31:0] mem [256];
    int n_chk = 0, n_pass = 0;
    int wr_cnt = 0, rd_cnt = 0, err_seen = 0;
    int rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event seen with nothing expected", name);
    endtask

    // Register file responder: data valid exactly one cycle after reg_rd
    always @(posedge sys_clk)
        reg_rdata <= (reg_rd === 1'b1) ? mem[reg_addr] : 32'hDEAD_BEEF;

    initial begin
        tx_data_ready = 1'b1;
        forever begin
            @(posedge sys_clk); #1;
            case (rdy_mode)
                0:       tx_data_ready = 1'b1;
                1:       tx_data_ready = ($urandom_range(0, 2) != 0);
                default: tx_data_ready = 1'b0;
            endcase
        end
    end

    always @(negedge sys_clk) begin
        if (reg_wr === 1'b1) begin
            wr_cnt++;
            if (wr_q.size() == 0) fail_now("reg_wr_unexpected");
            else check("reg_wr", {23'd0, reg_rd, reg_addr, reg_wdata}, {24'd0, wr_q.pop_front()});
        end
        if (reg_rd === 1'b1) rd_cnt++;
        if (tx_data_valid === 1'b1 && tx_data_ready) begin
            if (tx_q.size() == 0) fail_now("tx_unexpected");
            else check("tx_data", tx_data, tx_q.pop_front());
        end
        if (cmd_error === 1'b1) err_seen++;
    end

    task automatic tick();
        @(posedge sys_clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [31:0] w);
        rx_data = w; rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0; rx_data = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin tick(); n++; end
        check(name, busy, 0);
    endtask

    task automatic wait_txv(input string name);
        int n;
        n = 0;
        while (tx_data_valid !== 1'b1 && n < 50) begin tick(); n++; end
        check(name, tx_data_valid, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input int n, input int max_gap);
        logic [31:0] d;
        send({1'b0, 7'(n - 1), 16'h0, a});
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            wr_q.push_back({8'(a + i), d});
            idle($urandom_range(0, max_gap));
            send(d);
        end
        check("busy_after_write", busy, 0);
        idle(1);
    endtask

    task automatic do_read(input logic [7:0] a, input int n, input int max_gap);
        int rd0;
        rd0 = rd_cnt;
        for (int i = 0; i < n; i++) tx_q.push_back(mem[8'(a + i)]);
        send({1'b1, 7'(n - 1), 16'h0, a});
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, max_gap));
            send($urandom);
        end
        wait_idle("read_idle");
        idle(1);
        check("read_rd_count", rd_cnt - rd0, n);
        check("read_tx_drained", tx_q.size(), 0);
    endtask

    initial begin
        int rd0, w0, e0;
        logic [31:0] d;
        sys_rst = 1'b1; rx_data = '0; rx_data_valid = 1'b0;
        frame_abort = 1'b0; tx_error = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
        idle(3);
        check("reset_data", {tx_data, reg_wdata}, 0);
        check("reset_ctl", {tx_data_valid, reg_wr, reg_rd, reg_addr, cmd_error, busy, underrun_cnt}, 0);
        sys_rst = 1'b0;
        idle(1);

        // Two-word write at 0x10
        wr_q.push_back({8'h10, 32'hAAAA_0001});
        wr_q.push_back({8'h11, 32'hAAAA_0002});
        send(32'h0100_0010);
        send(32'hAAAA_0001);
        send(32'hAAAA_0002);
        check("busy_low_after_2nd", busy, 0);
        idle(2);
        check("write2_drained", wr_q.size(), 0);

        // Three-word read wrapping 0xFE -> 0x00
        do_read(8'hFE, 3, 0);

        // Stalled transmit FIFO holds data and blocks the next read
        rdy_mode = 2;
        rd0 = rd_cnt;
        tx_q.push_back(mem[8'h40]);
        tx_q.push_back(mem[8'h41]);
        send(32'h8100_0040);
        wait_txv("stall_txv_up");
        for (int i = 0; i < 10; i++) begin
            check("stall_hold", {tx_data_valid, tx_data}, {1'b1, mem[8'h40]});
            tick();
        end
        check("stall_one_rd", rd_cnt - rd0, 1);
        rdy_mode = 0;
        send($urandom);
        send($urandom);
        wait_idle("stall_idle");
        idle(1);
        check("stall_rd_total", rd_cnt - rd0, 2);
        check("stall_tx_drained", tx_q.size(), 0);

        // Malformed command, then a good one
        e0 = err_seen;
        send(32'h0000_1200);
        idle(2);
        check("cmd_error_pulse", err_seen - e0, 1);
        check("cmd_error_idle", busy, 0);
        do_write(8'h20, 2, 1);
        check("after_err_write", wr_q.size(), 0);

        // Abort on the 2nd word of a 4-word write
        w0 = wr_cnt;
        send(32'h0300_0050);
        d = $urandom;
        wr_q.push_back({8'h50, d});
        send(d);
        frame_abort = 1'b1;
        send($urandom);
        frame_abort = 1'b0;
        check("abort_write_idle", busy, 0);
        idle(3);
        check("abort_write_count", wr_cnt - w0, 1);
        check("abort_write_queue", wr_q.size(), 0);

        // Abort while a read word is offered
        rdy_mode = 2;
        tx_q.push_back(mem[8'h60]);
        send(32'h8000_0060);
        wait_txv("abort_rd_txv_up");
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        check("abort_read", {busy, tx_data_valid}, 0);
        tx_q.delete();
        rdy_mode = 0;
        idle(2);

        // Reset in the middle of a write burst
        w0 = wr_cnt;
        send(32'h0300_0030);
        d = $urandom;
        wr_q.push_back({8'h30, d});
        send(d);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("midreset_outputs", {busy, reg_wr, reg_rd, reg_addr}, 0);
        send($urandom & 32'h7FFF_FFFF & ~32'h00FF_FF00);
        check("midreset_new_cmd_busy", busy, 1);
        frame_abort = 1'b1; tick(); frame_abort = 1'b0;
        idle(2);
        check("midreset_wr_count", wr_cnt - w0, 1);

        // Underrun counter saturation
        for (int i = 0; i < 300; i++) begin
            tx_error = 1'b1; tick();
            tx_error = 1'b0; tick();
            if (i == 99) check("underrun_100", underrun_cnt, 100);
        end
        check("underrun_sat", underrun_cnt, 255);

        // Maximum burst length, wrapping the address
        do_write(8'hF0, 128, 0);

        // Randomized bursts
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write(8'($urandom), $urandom_range(1, 6), 2);
            end else begin
                rdy_mode = 1;
                do_read(8'($urandom), $urandom_range(1, 5), 3);
                rdy_mode = 0;
            end
        end
        idle(2);
        check("final_wr_queue", wr_q.size(), 0);
        check("final_err_total", err_seen, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
